// File: rtl/lc3b_types.sv
// lc3b_types: shared arbitration enums and index helper for the Wishbone arbiter
package lc3b_types;
    typedef enum logic {ARB_FIXED, ARB_RR} arb_mode_t;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction
endpackage

// File: rtl/wb_rr_picker.sv
// wb_rr_picker: combinational fixed-priority / round-robin winner selection
module wb_rr_picker
    import lc3b_types::*;
#(
    parameter int NUM_PORTS = 2,
    localparam int IW = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        rr_ptr,
    input  arb_mode_t            mode,
    output logic [NUM_PORTS-1:0] win_oh,
    output logic [IW-1:0]        win_idx
);
    int start;
    int p;
    // Scan from the back of the search order so the first requester in order is written last.
    always_comb begin
        start = (mode == ARB_RR) ? int'(rr_ptr) : 0;
        p = 0;
        win_oh = '0;
        win_idx = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            p = wrap_add(start, k, NUM_PORTS);
            if (req[p]) begin
                win_oh = '0;
                win_oh[p] = 1'b1;
                win_idx = IW'(p);
            end
        end
    end
endmodule

// File: rtl/wb_arbiter_n.sv
// wb_arbiter_n: N-port Wishbone arbiter feeding a single downstream port
module wb_arbiter_n
    import lc3b_types::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADR_W = 12,
    parameter int DAT_W = 128,
    parameter int ARB_MODE = 0,
    localparam int SEL_W = DAT_W / 8,
    localparam int IW = $clog2(NUM_PORTS)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_PORTS-1:0]       s_cyc,
    input  logic [NUM_PORTS-1:0]       s_stb,
    input  logic [NUM_PORTS-1:0]       s_we,
    input  logic [NUM_PORTS*ADR_W-1:0] s_adr,
    input  logic [NUM_PORTS*DAT_W-1:0] s_dat_w,
    input  logic [NUM_PORTS*SEL_W-1:0] s_sel,
    output logic [DAT_W-1:0]           s_dat_r,
    output logic [NUM_PORTS-1:0]       s_ack,
    output logic [NUM_PORTS-1:0]       s_rty,
    output logic                       m_cyc,
    output logic                       m_stb,
    output logic                       m_we,
    output logic [ADR_W-1:0]           m_adr,
    output logic [DAT_W-1:0]           m_dat_w,
    output logic [SEL_W-1:0]           m_sel,
    input  logic [DAT_W-1:0]           m_dat_r,
    input  logic                       m_ack,
    input  logic                       m_rty,
    output logic [NUM_PORTS-1:0]       grant
);
    localparam arb_mode_t MODE = (ARB_MODE == 1) ? ARB_RR : ARB_FIXED;
    arb_state_t state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d, req, win_oh;
    logic [IW-1:0] gidx_q, gidx_d, rr_ptr_q, rr_ptr_d, win_idx;
    logic busy, g_cyc, g_req;
    assign req = s_cyc & s_stb;
    wb_rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .mode    (MODE),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );
    assign busy  = state_q == BUSY;
    assign g_cyc = s_cyc[gidx_q];
    assign g_req = g_cyc & s_stb[gidx_q];
    // A dropped s_cyc ends the transaction like an ACK/RTY, but nothing is forwarded upstream.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d = gidx_q;
        rr_ptr_d = rr_ptr_q;
        if (state_q == IDLE && |req) begin
            state_d = BUSY;
            grant_d = win_oh;
            gidx_d = win_idx;
        end else if (busy && (!g_cyc || m_ack || m_rty)) begin
            state_d = DONE;
            grant_d = '0;
            rr_ptr_d = IW'(wrap_add(int'(gidx_q), 1, NUM_PORTS));
        end else if (!busy && state_q != IDLE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end
    assign m_cyc   = busy & g_req;
    assign m_stb   = busy & g_req;
    assign m_we    = busy & s_we[gidx_q];
    assign m_adr   = busy ? s_adr[int'(gidx_q)*ADR_W +: ADR_W] : '0;
    assign m_dat_w = busy ? s_dat_w[int'(gidx_q)*DAT_W +: DAT_W] : '0;
    assign m_sel   = busy ? s_sel[int'(gidx_q)*SEL_W +: SEL_W] : '0;
    assign s_ack   = (busy & g_cyc & m_ack) ? grant_q : '0;
    assign s_rty   = (busy & g_cyc & m_rty & ~m_ack) ? grant_q : '0;
    assign s_dat_r = m_dat_r;
    assign grant   = grant_q;
endmodule

// File: doc/wb_arbiter_n.md
# wb_arbiter_n

Parametrised N-port Wishbone arbiter: multiplexes NUM_PORTS Wishbone masters (ifetch, data, prefetcher, DMA, ...) onto a single downstream Wishbone port feeding the L2 cache. It generalises the two-port ifetch/memory interconnect with a configurable port count, configurable bus widths, selectable fixed-priority or round-robin arbitration, retry passthrough, and abort handling. It sits between the CPU-side master ports and the L2 cache.

## Interface
- NUM_PORTS, 2: number of upstream masters (2..8)
- ADR_W, 12: address width (line address)
- DAT_W, 128: data width; SEL_W = DAT_W/8
- ARB_MODE, 0: 0 = fixed priority (port 0 highest), 1 = round-robin
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous, active-high reset
- s_cyc, s_stb, s_we  in  NUM_PORTS each  per-port Wishbone controls
- s_adr  in  NUM_PORTS*ADR_W  packed, port i at [i*ADR_W +: ADR_W]
- s_dat_w  in  NUM_PORTS*DAT_W  per-port write data
- s_sel  in  NUM_PORTS*SEL_W  per-port byte selects
- s_dat_r  out  DAT_W  read data, broadcast to all ports
- s_ack, s_rty  out  NUM_PORTS  per-port ACK/RTY, only the granted bit can be 1
- m_cyc, m_stb, m_we  out  1  downstream controls
- m_adr  out  ADR_W; m_dat_w  out  DAT_W; m_sel  out  SEL_W
- m_dat_r  in  DAT_W; m_ack, m_rty  in  1
- grant  out  NUM_PORTS  registered one-hot grant (zero when idle)

## Operation
- Request on port i: s_cyc[i] & s_stb[i].
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any request, the winner is selected and grant is registered; go to BUSY. If there is no request, stay in IDLE.
- Fixed mode: the lowest-index requester wins.
- Round-robin mode: the search starts at rr_ptr and wraps modulo NUM_PORTS. On leaving BUSY, rr_ptr = (granted index + 1) mod NUM_PORTS.
- BUSY:
  - m_cyc/m_stb/m_we/m_adr/m_dat_w/m_sel combinationally mux the granted port's inputs.
  - m_cyc and m_stb are gated by the granted port's s_cyc & s_stb.
  - s_ack[g] = m_ack and s_rty[g] = m_rty, combinational in the same cycle.
  - On m_ack or m_rty, go to DONE.
- Abort: if the granted s_cyc drops in BUSY, m_cyc/m_stb drop in that same cycle, no ACK is forwarded, and the FSM goes to DONE.
- DONE: all m_* controls are 0 and grant is cleared; go to IDLE next cycle. This dead cycle guarantees the master has deasserted STB before re-arbitration, so one request is never issued twice.
- s_dat_r = m_dat_r at all times.
- Non-requesting ports see s_ack = s_rty = 0 at all times.
- Requests arriving while BUSY/DONE are held by their masters and arbitrated in the next IDLE.

## Timing
- Reset values:
  - state = IDLE, grant = 0, rr_ptr = 0.
  - m_cyc = m_stb = m_we = 0.
  - m_adr, m_dat_w, m_sel = 0.
  - s_ack = s_rty = 0.
- Reset mid-BUSY: next cycle state is IDLE and all outputs are at reset values. An in-flight downstream ACK after reset is ignored.
- Latency: request seen in IDLE at cycle t → m_stb = 1 at cycle t+1.
- ACK path: combinational, zero added cycles.
- Back-to-back issue rate: one transaction per (downstream latency + 2) cycles (arbitration cycle plus DONE cycle).
- Simultaneous m_ack and m_rty: treated as ACK; s_rty is suppressed.
- Index width is clog2(NUM_PORTS). For non-power-of-two NUM_PORTS, rr_ptr wraps from NUM_PORTS-1 to 0.

## Structure
- Shared package (lc3b_types): arb_mode_t enum (ARB_FIXED, ARB_RR) and arb_state_t enum (IDLE, BUSY, DONE).
- Sub-module wb_rr_picker: combinational, parametrised by NUM_PORTS.
  - Inputs: request vector, rr_ptr, mode.
  - Outputs: one-hot winner and winner index.
- Top: FSM, grant/rr_ptr registers, and output muxes.

## Test plan
- Single request: NUM_PORTS=3, RR mode, port 1 reads adr 0x0A5, slave ACKs 2 cycles after m_stb with data 0xDEAD…
  - Required: m_stb at t+1, grant=3'b010, s_ack[1] pulses once with s_dat_r=0xDEAD…
  - Required: state passes through DONE, then IDLE.
- Fixed priority: ports 0, 1, 2 all request continuously for 3 transactions.
  - Required: grant sequence 001, 001, 001; ports 1 and 2 are starved.
- Round-robin: ports 0, 1, 2 all request continuously for 3 transactions.
  - Required: grant sequence 001, 010, 100; rr_ptr is 0 afterwards.
- Retry: slave asserts m_rty for port 2's write.
  - Required: s_rty[2]=1 for one cycle and s_ack=0.
  - Required: port 2 re-requests and is re-arbitrated after DONE.
- Abort: port 0 drops s_cyc two cycles into BUSY.
  - Required: m_cyc=0 in the same cycle, no s_ack, DONE → IDLE.
  - Required: the pending port 1 is granted next.
- Reset mid-BUSY: RST asserted while port 1 is in BUSY.
  - Required: next cycle all outputs are 0 and grant=0.
  - Required: a late m_ack produces no s_ack.
